// File: rtl/axi_apb_pkg.sv
// rtl/axi_apb_pkg.sv - shared types and helpers for the AXI4-Lite to APB4 bridge
package axi_apb_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_e;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } bridge_state_e;

    // Slave index width; a single slave still needs one bit to index with
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/axi_apb_bridge_nslv_if.sv
// rtl/axi_apb_bridge_nslv_if.sv - AXI4-Lite channel bundle with master/slave views
interface axi_apb_bridge_nslv_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic [ADDR_W-1:0] aw_addr;
    logic              aw_valid;
    logic              aw_ready;
    logic [DATA_W-1:0] w_data;
    logic [STRB_W-1:0] w_strb;
    logic              w_valid;
    logic              w_ready;
    logic [1:0]        b_resp;
    logic              b_valid;
    logic              b_ready;
    logic [ADDR_W-1:0] ar_addr;
    logic              ar_valid;
    logic              ar_ready;
    logic [DATA_W-1:0] r_data;
    logic [1:0]        r_resp;
    logic              r_valid;
    logic              r_ready;

    modport master (
        output aw_addr, aw_valid, input aw_ready,
        output w_data, w_strb, w_valid, input w_ready,
        input  b_resp, b_valid, output b_ready,
        output ar_addr, ar_valid, input ar_ready,
        input  r_data, r_resp, r_valid, output r_ready
    );

    modport slave (
        input  aw_addr, aw_valid, output aw_ready,
        input  w_data, w_strb, w_valid, output w_ready,
        output b_resp, b_valid, input b_ready,
        input  ar_addr, ar_valid, output ar_ready,
        output r_data, r_resp, r_valid, input r_ready
    );

endinterface

// File: rtl/apb_addr_decoder.sv
// rtl/apb_addr_decoder.sv - maps an address onto a peripheral region: hit, index, one-hot select
module apb_addr_decoder
    import axi_apb_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                NUM_SLV    = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 'h3000_0000,
    parameter int                REGION_LSB = 12
) (
    input  logic [ADDR_W-1:0]               addr,
    output logic                            hit,
    output logic [idx_width(NUM_SLV)-1:0]   idx,
    output logic [NUM_SLV-1:0]              sel
);
    localparam int IDX_W = idx_width(NUM_SLV);

    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] region;

    // Below-base addresses wrap on subtraction, so the base compare guards them explicitly
    always_comb begin
        offset = addr - BASE_ADDR;
        region = offset >> REGION_LSB;
        hit    = (addr >= BASE_ADDR) && (region < ADDR_W'(NUM_SLV));
        idx    = region[IDX_W-1:0];
        sel    = hit ? (NUM_SLV'(1) << idx) : '0;
    end

endmodule

// File: rtl/axi_apb_bridge_nslv.sv
// rtl/axi_apb_bridge_nslv.sv - AXI4-Lite slave to APB4 master, NUM_SLV peripherals; APB_TIMEOUT_EN adds an ACCESS watchdog
module axi_apb_bridge_nslv
    import axi_apb_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                NUM_SLV     = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 'h3000_0000,
    parameter int                REGION_LSB  = 12,
    parameter int                TIMEOUT_CYC = 256
) (
    input  logic                      apb_axi_clk,
    input  logic                      a_reset_n,
    axi_apb_bridge_nslv_if.slave      axi,
    output logic [ADDR_W-1:0]         p_addr,
    output logic [DATA_W-1:0]         p_wdata,
    output logic [DATA_W/8-1:0]       p_strb,
    output logic                      p_write,
    output logic [NUM_SLV-1:0]        p_sel,
    output logic                      p_enable,
    input  logic [NUM_SLV-1:0]        p_ready,
    input  logic [NUM_SLV*DATA_W-1:0] p_rdata,
    input  logic [NUM_SLV-1:0]        p_slverr
);
    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = idx_width(NUM_SLV);

    bridge_state_e     state, state_nxt;

    logic              aw_ready_q, ar_ready_q;
    logic              aw_ready_d, ar_ready_d;
    logic              prio_read_q;
    logic              is_write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] strb_q;
    logic [DATA_W-1:0] rdata_q;
    logic [IDX_W-1:0]  idx_q;
    logic [NUM_SLV-1:0] sel_q;
    resp_e             resp_q;

    logic [ADDR_W-1:0] dec_addr;
    logic              dec_hit;
    logic [IDX_W-1:0]  dec_idx;
    logic [NUM_SLV-1:0] dec_sel;

    logic              wr_hs, rd_hs;
    logic              pending, wr_elig, rd_elig, pick_wr, pick_rd, arb_open;
    logic              slv_ready, slv_err;
    logic [DATA_W-1:0] slv_rdata;
    logic              b_valid_int, r_valid_int, resp_done;
    logic              timeout;

    // The armed ready tells which channel's address is being accepted this cycle
    assign dec_addr = aw_ready_q ? axi.aw_addr : axi.ar_addr;

    apb_addr_decoder #(
        .ADDR_W     (ADDR_W),
        .NUM_SLV    (NUM_SLV),
        .BASE_ADDR  (BASE_ADDR),
        .REGION_LSB (REGION_LSB)
    ) u_dec (
        .addr (dec_addr),
        .hit  (dec_hit),
        .idx  (dec_idx),
        .sel  (dec_sel)
    );

    // Readies are registered pulses, so they never follow valid combinationally
    assign wr_hs    = (state == IDLE) && aw_ready_q && axi.aw_valid && axi.w_valid;
    assign rd_hs    = (state == IDLE) && ar_ready_q && axi.ar_valid;
    assign pending  = aw_ready_q | ar_ready_q;
    assign wr_elig  = axi.aw_valid & axi.w_valid;
    assign rd_elig  = axi.ar_valid;
    assign pick_rd  = rd_elig & (~wr_elig | prio_read_q);
    assign pick_wr  = wr_elig & ~pick_rd;
    // Arming during the last RESP cycle keeps back-to-back transfers at four cycles each
    assign arb_open = ((state == IDLE) && !pending) || ((state == RESP) && resp_done);
    assign aw_ready_d = arb_open & pick_wr;
    assign ar_ready_d = arb_open & pick_rd;

    assign slv_ready = p_ready[idx_q];
    assign slv_err   = p_slverr[idx_q];
    assign slv_rdata = p_rdata[idx_q*DATA_W +: DATA_W];

    assign b_valid_int = (state == RESP) && is_write_q;
    assign r_valid_int = (state == RESP) && !is_write_q;
    assign resp_done   = is_write_q ? axi.b_ready : axi.r_ready;

`ifdef APB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_cnt;

    // Counts ACCESS cycles; SETUP always precedes ACCESS, so clearing there restarts it per transfer
    always_ff @(posedge apb_axi_clk or negedge a_reset_n) begin
        if (!a_reset_n)             tmo_cnt <= '0;
        else if (state == SETUP)    tmo_cnt <= '0;
        else if (state == ACCESS)   tmo_cnt <= tmo_cnt + 1'b1;
    end

    assign timeout = (state == ACCESS) && !slv_ready && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC == 0);
    assign timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge apb_axi_clk or negedge a_reset_n) begin
        if (!a_reset_n) state <= IDLE;
        else            state <= state_nxt;
    end

    // Next state: decode misses skip the APB phases and answer straight away
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (wr_hs || rd_hs) state_nxt = dec_hit ? SETUP : RESP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (slv_ready || timeout) state_nxt = RESP;
            RESP:    if (resp_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture, arbitration history and response collection
    always_ff @(posedge apb_axi_clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            aw_ready_q  <= 1'b0;
            ar_ready_q  <= 1'b0;
            prio_read_q <= 1'b1;
            is_write_q  <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            strb_q      <= '0;
            rdata_q     <= '0;
            idx_q       <= '0;
            sel_q       <= '0;
            resp_q      <= OKAY;
        end else begin
            aw_ready_q <= aw_ready_d;
            ar_ready_q <= ar_ready_d;
            if (wr_hs || rd_hs) begin
                prio_read_q <= wr_hs;
                is_write_q  <= wr_hs;
                addr_q      <= dec_addr;
                wdata_q     <= wr_hs ? axi.w_data : '0;
                strb_q      <= wr_hs ? axi.w_strb : '0;
                rdata_q     <= '0;
                idx_q       <= dec_idx;
                sel_q       <= dec_sel;
                resp_q      <= dec_hit ? OKAY : DECERR;
            end
            if (state == ACCESS) begin
                if (slv_ready) begin
                    resp_q <= slv_err ? SLVERR : OKAY;
                    if (!is_write_q) rdata_q <= slv_rdata;
                end else if (timeout) begin
                    resp_q <= SLVERR;
                end
            end
        end
    end

    assign axi.aw_ready = aw_ready_q;
    assign axi.w_ready  = aw_ready_q;
    assign axi.ar_ready = ar_ready_q;
    assign axi.b_valid  = b_valid_int;
    assign axi.r_valid  = r_valid_int;
    assign axi.b_resp   = b_valid_int ? resp_q : OKAY;
    assign axi.r_resp   = r_valid_int ? resp_q : OKAY;
    assign axi.r_data   = rdata_q;

    assign p_addr   = addr_q;
    assign p_wdata  = wdata_q;
    assign p_strb   = strb_q;
    assign p_write  = is_write_q;
    assign p_sel    = ((state == SETUP) || (state == ACCESS)) ? sel_q : '0;
    assign p_enable = (state == ACCESS);

endmodule

// File: tb/tb_axi_apb_bridge_nslv.sv
// tb/tb_axi_apb_bridge_nslv.sv - directed self-checking bench for axi_apb_bridge_nslv
module tb_axi_apb_bridge_nslv;

    logic clk;
    logic rst_n;

    logic [31:0]  p_addr;
    logic [31:0]  p_wdata;
    logic [3:0]   p_strb;
    logic         p_write;
    logic [3:0]   p_sel;
    logic         p_enable;
    logic [3:0]   p_ready;
    logic [127:0] p_rdata;
    logic [3:0]   p_slverr;
    logic [31:0]  slv_rdata [4];

    int n_cmp = 0;
    int n_bad = 0;

    logic [3:0] sel_seen;
    logic [7:0] grant_log;
    int         en_cnt;
    int         wr_access;
    int         ar_ready_cnt;

    axi_apb_bridge_nslv_if #(.ADDR_W(32), .DATA_W(32)) axi ();

    axi_apb_bridge_nslv #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .NUM_SLV     (4),
        .BASE_ADDR   (32'h3000_0000),
        .REGION_LSB  (12),
        .TIMEOUT_CYC (16)
    ) dut (
        .apb_axi_clk (clk),
        .a_reset_n   (rst_n),
        .axi         (axi),
        .p_addr      (p_addr),
        .p_wdata     (p_wdata),
        .p_strb      (p_strb),
        .p_write     (p_write),
        .p_sel       (p_sel),
        .p_enable    (p_enable),
        .p_ready     (p_ready),
        .p_rdata     (p_rdata),
        .p_slverr    (p_slverr)
    );

    assign p_rdata = {slv_rdata[3], slv_rdata[2], slv_rdata[1], slv_rdata[0]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus observers sampled mid-cycle
    always @(negedge clk) begin
        sel_seen = sel_seen | p_sel;
        if (axi.aw_ready) grant_log = {grant_log[6:0], 1'b1};
        if (axi.ar_ready) begin
            grant_log = {grant_log[6:0], 1'b0};
            ar_ready_cnt++;
        end
        if (p_enable) en_cnt++;
        if (p_enable && p_write && |(p_sel & p_ready)) wr_access++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] rs, output int lat);
        int n;
        @(posedge clk); #1;
        axi.aw_addr = a; axi.aw_valid = 1'b1;
        axi.w_data = d; axi.w_strb = s; axi.w_valid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!axi.aw_ready && n < 200);
        check_val("aw_handshake", axi.aw_ready, 1);
        check_val("w_ready_with_aw", axi.w_ready, 1);
        @(posedge clk); #1;
        axi.aw_valid = 1'b0; axi.w_valid = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!axi.b_valid && lat < 300);
        check_val("b_valid_seen", axi.b_valid, 1);
        rs = axi.b_resp;
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d,
                            output logic [1:0] rs, output int lat);
        int n;
        @(posedge clk); #1;
        axi.ar_addr = a; axi.ar_valid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!axi.ar_ready && n < 200);
        check_val("ar_handshake", axi.ar_ready, 1);
        @(posedge clk); #1;
        axi.ar_valid = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!axi.r_valid && lat < 300);
        check_val("r_valid_seen", axi.r_valid, 1);
        d  = axi.r_data;
        rs = axi.r_resp;
    endtask

    initial begin
        logic [1:0]  rs_a, rs_b, rs_c, rs_d;
        logic [31:0] d_a, d_b;
        int          lat_a, lat_b, lat_c, lat_d;
        int          n;
        int          wr_before;
        logic        b_stable;

        rst_n = 1'b0;
        axi.aw_addr = '0; axi.aw_valid = 1'b0;
        axi.w_data = '0; axi.w_strb = '0; axi.w_valid = 1'b0;
        axi.b_ready = 1'b1;
        axi.ar_addr = '0; axi.ar_valid = 1'b0;
        axi.r_ready = 1'b1;
        p_ready = 4'hF;
        p_slverr = 4'h0;
        slv_rdata[0] = 32'h0000_1111;
        slv_rdata[1] = 32'h1111_0000;
        slv_rdata[2] = 32'h2222_2222;
        slv_rdata[3] = 32'hDEAD_BEEF;
        sel_seen = '0; grant_log = '0; en_cnt = 0; wr_access = 0; ar_ready_cnt = 0;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_val("rst_p_sel", p_sel, 0);
        check_val("rst_p_enable", p_enable, 0);
        check_val("rst_ready", {axi.aw_ready, axi.w_ready, axi.ar_ready}, 0);
        check_val("rst_valid", {axi.b_valid, axi.r_valid}, 0);
        check_val("rst_p_write", p_write, 0);

        // Single write to slave1, checked cycle by cycle
        @(posedge clk); #1;
        axi.aw_addr = 32'h3000_1004; axi.aw_valid = 1'b1;
        axi.w_data = 32'hA5A5_0001; axi.w_strb = 4'hF; axi.w_valid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!axi.aw_ready && n < 50);
        check_val("wr1_handshake", {axi.aw_ready, axi.w_ready}, 2'b11);
        @(posedge clk); #1;
        axi.aw_valid = 1'b0; axi.w_valid = 1'b0;
        @(negedge clk);
        check_val("wr1_c1_sel", p_sel, 4'b0010);
        check_val("wr1_c1_enable", p_enable, 0);
        check_val("wr1_c1_addr", p_addr, 32'h3000_1004);
        check_val("wr1_c1_wdata", p_wdata, 32'hA5A5_0001);
        check_val("wr1_c1_strb_write", {p_strb, p_write}, 5'b11111);
        @(negedge clk);
        check_val("wr1_c2_sel", p_sel, 4'b0010);
        check_val("wr1_c2_enable", p_enable, 1);
        @(negedge clk);
        check_val("wr1_c3_b_valid", axi.b_valid, 1);
        check_val("wr1_c3_b_resp", axi.b_resp, 2'b00);
        check_val("wr1_c3_sel_off", {p_sel, p_enable}, 0);

        // Simultaneous read and write traffic, alternating grants starting with read
        grant_log = '0;
        wr_before = wr_access;
        fork
            begin
                axi_write(32'h3000_1000, 32'h0000_0011, 4'hF, rs_a, lat_a);
                axi_write(32'h3000_2008, 32'h0000_0022, 4'h3, rs_b, lat_b);
            end
            begin
                axi_read(32'h3000_0000, d_a, rs_c, lat_c);
                axi_read(32'h3000_3004, d_b, rs_d, lat_d);
            end
        join
        check_val("arb_order", grant_log[3:0], 4'b0101);
        check_val("arb_resps", {rs_a, rs_b, rs_c, rs_d}, 8'h00);
        check_val("arb_rd0", d_a, 32'h0000_1111);
        check_val("arb_rd3", d_b, 32'hDEAD_BEEF);
        check_val("arb_wr_count", wr_access - wr_before, 2);

        // Read from slave3 with five extra wait cycles
        p_ready[3] = 1'b0;
        fork
            axi_read(32'h3000_3000, d_a, rs_a, lat_a);
            begin
                n = 0;
                do begin @(negedge clk); n++; end while (!p_enable && n < 100);
                check_val("slow_access", p_enable, 1);
                repeat (5) @(negedge clk);
                check_val("slow_no_early_valid", axi.r_valid, 0);
                check_val("slow_enable_held", {p_sel, p_enable}, 5'b10001);
                p_ready[3] = 1'b1;
            end
        join
        check_val("slow_rdata", d_a, 32'hDEAD_BEEF);
        check_val("slow_rresp", rs_a, 2'b00);

        // Decode misses: below base and one region past the last slave
        sel_seen = '0;
        axi_read(32'h2000_0000, d_a, rs_a, lat_a);
        check_val("dec_lo_resp", rs_a, 2'b11);
        check_val("dec_lo_data", d_a, 0);
        check_val("dec_lo_lat", lat_a, 1);
        axi_read(32'h3000_4000, d_b, rs_b, lat_b);
        check_val("dec_hi_resp", rs_b, 2'b11);
        check_val("dec_hi_data", d_b, 0);
        check_val("dec_hi_lat", lat_b, 1);
        check_val("dec_no_psel", sel_seen, 0);

        // Minimum latency on a plain hit
        axi_read(32'h3000_0010, d_a, rs_a, lat_a);
        check_val("min_lat_read", lat_a, 3);

        // Slave error with a stalled response channel; a queued read must wait
        p_slverr[2] = 1'b1;
        axi.b_ready = 1'b0;
        axi_write(32'h3000_2000, 32'hCAFE_0002, 4'hF, rs_a, lat_a);
        check_val("slverr_resp", rs_a, 2'b10);
        axi.ar_addr = 32'h3000_0000; axi.ar_valid = 1'b1;
        ar_ready_cnt = 0;
        b_stable = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (!axi.b_valid || axi.b_resp != 2'b10) b_stable = 1'b0;
        end
        check_val("slverr_hold_stable", b_stable, 1);
        check_val("slverr_hold_no_grant", ar_ready_cnt, 0);
        @(posedge clk); #1;
        axi.b_ready = 1'b1;
        p_slverr[2] = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!axi.ar_ready && n < 50);
        check_val("after_hold_ar", axi.ar_ready, 1);
        @(posedge clk); #1;
        axi.ar_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!axi.r_valid && n < 50);
        check_val("after_hold_rdata", {axi.r_valid, axi.r_data}, {1'b1, 32'h0000_1111});

`ifdef APB_TIMEOUT_EN
        // Unresponsive slave0 is abandoned after sixteen ACCESS cycles
        p_ready[0] = 1'b0;
        en_cnt = 0;
        axi_read(32'h3000_0020, d_a, rs_a, lat_a);
        check_val("tmo_resp", rs_a, 2'b10);
        check_val("tmo_data", d_a, 0);
        check_val("tmo_access_cycles", en_cnt, 16);
        p_ready[0] = 1'b1;
`endif

        // Reset in the middle of an ACCESS phase
        p_ready[1] = 1'b0;
        @(posedge clk); #1;
        axi.ar_addr = 32'h3000_1000; axi.ar_valid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!axi.ar_ready && n < 50);
        @(posedge clk); #1;
        axi.ar_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!p_enable && n < 50);
        check_val("mid_rst_access", p_enable, 1);
        #2 rst_n = 1'b0;
        #1;
        check_val("mid_rst_apb_off", {p_sel, p_enable, p_write}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        p_ready[1] = 1'b1;
        @(negedge clk);
        check_val("mid_rst_no_resp", {axi.r_valid, axi.b_valid, axi.ar_ready}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
